rv32i_instr_encoder: RTL and testbench

Assembles RV32I 32-bit instruction words from decoded fields, the inverse of the instruction-to-control decode path. It is used by the bring-up instruction generator to feed instruction memory and the controller under test. It accepts field requests over valid/ready, checks legality and range, and packs the word per R/I/S/B/U/J format. It buffers results in a small output FIFO and flags and counts rejected requests.

---
 rtl/rv32i_instr_encoder.sv | 153 +++++++++++++++
 tb/tb_rv32i_instr_encoder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_instr_encoder.sv
// RV32I instruction word assembler: field requests in, packed words out through
// a small FIFO, with legality/range checks and saturating emit/error counters.
module rv32i_instr_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             alt,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] emit_count,
    output logic [CNT_W-1:0] err_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    logic [31:0] word;
    logic [1:0]  code;
    logic [6:0]  f7;
    logic        shift;
    logic        s12;
    logic        s13;
    logic        s21;

    always_comb begin
        word  = '0;
        code  = 2'd0;
        f7    = alt ? 7'b0100000 : 7'b0000000;
        shift = (funct3 == 3'd1) || (funct3 == 3'd5);
        s12   = (&imm[31:11]) || ~(|imm[31:11]);
        s13   = (&imm[31:12]) || ~(|imm[31:12]);
        s21   = (&imm[31:20]) || ~(|imm[31:20]);
        unique case (1'b1)
            (opcode == OP_R): begin
                word = {f7, rs2, rs1, funct3, rd, opcode};
                if (alt && !(funct3 == 3'd0 || funct3 == 3'd5)) code = 2'd1;
            end
            (opcode == OP_I): begin
                if (shift) begin
                    word = {f7, imm[4:0], rs1, funct3, rd, opcode};
                    if (alt && funct3 != 3'd5) code = 2'd1;
                    else if (|imm[31:5]) code = 2'd2;
                end else begin
                    word = {imm[11:0], rs1, funct3, rd, opcode};
                    if (alt) code = 2'd1;
                    else if (!s12) code = 2'd2;
                end
            end
            (opcode == OP_LD): begin
                word = {imm[11:0], rs1, funct3, rd, opcode};
                if (funct3 == 3'd3 || funct3 >= 3'd6) code = 2'd1;
                else if (!s12) code = 2'd2;
            end
            (opcode == OP_JALR): begin
                word = {imm[11:0], rs1, funct3, rd, opcode};
                if (funct3 != 3'd0) code = 2'd1;
                else if (!s12) code = 2'd2;
            end
            (opcode == OP_S): begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                if (funct3 > 3'd2) code = 2'd1;
                else if (!s12) code = 2'd2;
            end
            (opcode == OP_B): begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3,
                        imm[4:1], imm[11], opcode};
                if (funct3 == 3'd2 || funct3 == 3'd3) code = 2'd1;
                else if (imm[0]) code = 2'd3;
                else if (!s13) code = 2'd2;
            end
            (opcode == OP_LUI || opcode == OP_AUIPC): begin
                word = {imm[31:12], rd, opcode};
                if (|imm[11:0]) code = 2'd2;
            end
            (opcode == OP_JAL): begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                if (imm[0]) code = 2'd3;
                else if (!s21) code = 2'd2;
            end
            default: code = 2'd1;
        endcase
    end

    logic [31:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          accept;
    logic          push;
    logic          pop;
    logic          rej;

    // Readiness depends only on stored occupancy, never on out_ready
    assign in_ready  = rst_n && (cnt < FULL);
    assign out_valid = (cnt != '0);
    assign out_instr = out_valid ? mem[rp] : 32'h0;
    assign accept    = in_valid && in_ready;
    assign push      = accept && (code == 2'd0);
    assign rej       = accept && (code != 2'd0);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wp         <= '0;
            rp         <= '0;
            cnt        <= '0;
            err_pulse  <= 1'b0;
            err_code   <= 2'd0;
            emit_count <= '0;
            err_count  <= '0;
        end else begin
            if (push) begin
                mem[wp] <= word;
                wp      <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            err_pulse <= rej;
            if (rej) begin
                err_code <= code;
                if (err_count != '1) err_count <= err_count + 1'b1;
            end
            if (pop && emit_count != '1) emit_count <= emit_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Randomised bench for rv32i_instr_encoder against an arithmetic reference
// model of the RV32I formats and a queue-based FIFO model.
module tb_rv32i_instr_encoder;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [6:0]       opcode = '0;
    logic [2:0]       funct3 = '0;
    logic             alt = 1'b0;
    logic [4:0]       rd = '0;
    logic [4:0]       rs1 = '0;
    logic [4:0]       rs2 = '0;
    logic [31:0]      imm = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_instr;
    logic             err_pulse;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] emit_count;
    logic [CNT_W-1:0] err_count;

    rv32i_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .alt(alt),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr),
        .err_pulse(err_pulse), .err_code(err_code),
        .emit_count(emit_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nbad = 0;
    bit [31:0] q[$];
    bit        exp_pulse;
    bit [1:0]  exp_code;
    int        exp_emit;
    int        exp_errc;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        ncmp++;
        if (obs !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit in_range(bit [31:0] v, int bits);
        longint s = longint'($signed(v));
        longint lim = longint'(1) << (bits - 1);
        return (s >= -lim) && (s < lim);
    endfunction

    // Reference encoder from the format tables, using plain shifts and masks
    function automatic void ref_enc(bit [6:0] op, bit [2:0] f3, bit a,
                                    bit [4:0] d, bit [4:0] s1, bit [4:0] s2,
                                    bit [31:0] iv, output bit [31:0] w,
                                    output bit [1:0] c);
        bit [31:0] base;
        base = (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
        w = 0;
        c = 0;
        case (op)
            7'h33: begin
                w = ((a ? 32'h20 : 32'h0) << 25) | (32'(s2) << 20) | base
                    | (32'(d) << 7);
                if (a && !(f3 inside {0, 5})) c = 1;
            end
            7'h13: begin
                if (f3 inside {1, 5}) begin
                    w = ((a ? 32'h20 : 32'h0) << 25) | ((iv & 31) << 20)
                        | base | (32'(d) << 7);
                    if (a && f3 != 5) c = 1;
                    else if (iv > 31) c = 2;
                end else begin
                    w = ((iv & 32'hfff) << 20) | base | (32'(d) << 7);
                    if (a) c = 1;
                    else if (!in_range(iv, 12)) c = 2;
                end
            end
            7'h03, 7'h67: begin
                w = ((iv & 32'hfff) << 20) | base | (32'(d) << 7);
                if (op == 7'h03 && !(f3 inside {0, 1, 2, 4, 5})) c = 1;
                else if (op == 7'h67 && f3 != 0) c = 1;
                else if (!in_range(iv, 12)) c = 2;
            end
            7'h23: begin
                w = (((iv >> 5) & 127) << 25) | (32'(s2) << 20) | base
                    | ((iv & 31) << 7);
                if (f3 > 2) c = 1;
                else if (!in_range(iv, 12)) c = 2;
            end
            7'h63: begin
                w = (((iv >> 12) & 1) << 31) | (((iv >> 5) & 63) << 25)
                    | (32'(s2) << 20) | base | (((iv >> 1) & 15) << 8)
                    | (((iv >> 11) & 1) << 7);
                if (f3 inside {2, 3}) c = 1;
                else if (iv[0]) c = 3;
                else if (!in_range(iv, 13)) c = 2;
            end
            7'h37, 7'h17: begin
                w = (iv & 32'hfffff000) | (32'(d) << 7) | 32'(op);
                if ((iv & 32'hfff) != 0) c = 2;
            end
            7'h6f: begin
                w = (((iv >> 20) & 1) << 31) | (((iv >> 1) & 1023) << 21)
                    | (((iv >> 11) & 1) << 20) | (((iv >> 12) & 255) << 12)
                    | (32'(d) << 7) | 32'(op);
                if (iv[0]) c = 3;
                else if (!in_range(iv, 21)) c = 2;
            end
            default: c = 1;
        endcase
    endfunction

    task automatic set_req(input logic [6:0] op, input logic [2:0] f3,
                           input logic a, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2,
                           input logic [31:0] iv);
        opcode = op; funct3 = f3; alt = a;
        rd = d; rs1 = s1; rs2 = s2; imm = iv;
    endtask

    task automatic step(input bit v, input bit ordy);
        bit [31:0] w;
        bit [1:0]  c;
        bit acc;
        bit pp;
        @(negedge clk);
        in_valid = v;
        out_ready = ordy;
        #1;
        check("in_ready", in_ready, q.size() < DEPTH);
        check("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) check("out_instr", out_instr, q[0]);
        ref_enc(opcode, funct3, alt, rd, rs1, rs2, imm, w, c);
        acc = v && (q.size() < DEPTH);
        pp  = ordy && (q.size() != 0);
        @(posedge clk);
        if (pp) begin
            void'(q.pop_front());
            if (exp_emit != 255) exp_emit++;
        end
        exp_pulse = 0;
        if (acc) begin
            if (c == 0) q.push_back(w);
            else begin
                exp_pulse = 1;
                exp_code = c;
                if (exp_errc != 255) exp_errc++;
            end
        end
        #1;
        check("err_pulse", err_pulse, exp_pulse);
        check("err_code", err_code, exp_code);
        check("emit_count", emit_count, exp_emit);
        check("err_count", err_count, exp_errc);
    endtask

    task automatic clear_model();
        q.delete();
        exp_pulse = 0;
        exp_code = 0;
        exp_emit = 0;
        exp_errc = 0;
    endtask

    bit [6:0]  ops[9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23,
                          7'h63, 7'h37, 7'h17, 7'h6f};
    bit [31:0] bnd[14] = '{32'd2047, 32'd2048, 32'hfffff800, 32'hfffff7ff,
                           32'd31, 32'd32, 32'd4094, 32'd4096, 32'hfffff000,
                           32'hffffefff, 32'h000ffffe, 32'h00100000,
                           32'hfff00000, 32'd3};

    function automatic bit [31:0] pick_imm();
        case ($urandom_range(0, 6))
            0: return $urandom_range(0, 40);
            1: return bnd[$urandom_range(0, 13)];
            2: return $urandom;
            3: return $urandom & 32'hfffff000;
            4: return -$urandom_range(0, 5000);
            5: return $urandom_range(0, 5000) & ~32'd1;
            default: return ($urandom & 32'h001ffffe) | ($urandom_range(0, 1) ? 32'hffe00000 : 32'h0);
        endcase
    endfunction

    initial begin
        clear_model();
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_err_code", err_code, 0);
        check("rst_emit", emit_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        set_req(7'h33, 0, 0, 3, 1, 1, 0);
        step(1, 0); check("add_word", out_instr, 32'h001081b3);
        step(0, 1);
        set_req(7'h33, 0, 1, 3, 1, 1, 0);
        step(1, 0); check("sub_word", out_instr, 32'h401081b3);
        step(0, 1);
        set_req(7'h13, 0, 0, 3, 1, 0, 32'hffffffff);
        step(1, 0); check("addi_word", out_instr, 32'hfff08193);
        step(0, 1);
        set_req(7'h13, 5, 1, 3, 1, 0, 6);
        step(1, 0); check("srai_word", out_instr, 32'h4060d193);
        step(0, 1);
        set_req(7'h13, 1, 0, 3, 1, 0, 32);
        step(1, 1); check("slli_code", err_code, 2);
        set_req(7'h63, 0, 0, 0, 1, 2, 8);
        step(1, 0); check("beq_word", out_instr, 32'h00208463);
        step(0, 1);
        set_req(7'h63, 0, 0, 0, 1, 2, 3);
        step(1, 1); check("beq_mis_pulse", err_pulse, 1);
        check("beq_mis_code", err_code, 3);
        step(0, 1); check("beq_pulse_end", err_pulse, 0);
        set_req(7'h6f, 0, 0, 1, 0, 0, 32'h800);
        step(1, 0); check("jal_word", out_instr, 32'h001000ef);
        step(0, 1);
        set_req(7'h37, 0, 0, 5, 0, 0, 32'h12345000);
        step(1, 0); check("lui_word", out_instr, 32'h123452b7);
        step(0, 1);
        set_req(7'h37, 0, 0, 5, 0, 0, 32'h12345001);
        step(1, 1); check("lui_code", err_code, 2);

        set_req(7'h33, 0, 0, 7, 2, 3, 0);
        step(1, 0);
        set_req(7'h33, 0, 0, 8, 2, 3, 0);
        step(1, 0);
        set_req(7'h33, 0, 0, 9, 2, 3, 0);
        step(1, 0); check("bp_full", in_ready, 0);
        step(1, 1);
        step(1, 1);
        step(0, 1);
        step(0, 1);
        step(0, 1);

        set_req(7'h13, 0, 0, 4, 1, 0, 5);
        step(1, 0);
        step(1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_emit", emit_count, 0);
        check("mid_rst_errc", err_count, 0);
        clear_model();
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1);
        step(0, 1);

        for (int i = 0; i < 1500; i++) begin
            set_req($urandom_range(0, 9) == 0 ? 7'($urandom) : ops[$urandom_range(0, 8)],
                    3'($urandom), $urandom_range(0, 3) == 0,
                    5'($urandom), 5'($urandom), 5'($urandom), pick_imm());
            step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 4; i++) step(0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
